// File: rtl/kgp_fetch_pkg.sv
// Shared definitions for the KGP-RISC instruction fetch stage.
// The opcode field bounds are also used by the control decoder.
package kgp_fetch_pkg;
  localparam int INSTR_W    = 32;
  localparam int PC_STEP    = 4;
  localparam int OPCODE_MSB = 31;
  localparam int OPCODE_LSB = 28;

  typedef enum logic [1:0] {
    FETCH = 2'd0,  // request outstanding, output empty
    VALID = 2'd1,  // output register live
    DRAIN = 2'd2   // stale request outstanding after a redirect
  } fetch_state_e;

  // Program counter update selector driven by the fetch FSM.
  typedef enum logic [1:0] {
    PC_HOLD   = 2'd0,
    PC_INC    = 2'd1,
    PC_REDIR  = 2'd2,  // take redirect_pc directly
    PC_TARGET = 2'd3   // take the stored redirect target
  } pc_op_e;
endpackage

// File: rtl/fetch_pc.sv
// Program counter and pending-redirect target registers.
// Ports:
//   clk, rst        clock, async active-high reset
//   op              pc update select (hold / +4 / redirect / stored target)
//   tgt_we          capture redirect_pc into target
//   redirect_pc     redirect address, low two bits forced to zero
//   pc              current fetch address (always 4-aligned)
module fetch_pc
  import kgp_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic         clk,
  input  logic         rst,
  input  pc_op_e       op,
  input  logic         tgt_we,
  input  logic [31:0]  redirect_pc,
  output logic [31:0]  pc
);
  logic [31:0] target;
  logic [31:0] redir_aligned;

  assign redir_aligned = {redirect_pc[31:2], 2'b00};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc     <= {RESET_PC[31:2], 2'b00};
      target <= '0;
    end else begin
      if (tgt_we) target <= redir_aligned;
      case (op)
        PC_INC:    pc <= pc + 32'(PC_STEP);  // wraps modulo 2^32
        PC_REDIR:  pc <= redir_aligned;
        PC_TARGET: pc <= target;
        default:   pc <= pc;
      endcase
    end
  end
endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: owns the PC, issues imem requests, and holds one
// returned instruction for decode under a valid/stall handshake. Redirects
// flush the output; an in-flight response at redirect time is drained.
// Ports:
//   clk, rst                  clock, async active-high reset
//   imem_req/addr             request to instruction memory (addr = pc)
//   imem_ack/rdata            one-cycle response strobe and data
//   stall                     decode cannot accept this cycle
//   redirect_valid/pc         branch/jump redirect pulse and target
//   instr_valid/instr/opcode/instr_pc  registered output to decode
module instr_fetch
  import kgp_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                clk,
  input  logic                rst,
  output logic                imem_req,
  output logic [31:0]         imem_addr,
  input  logic                imem_ack,
  input  logic [INSTR_W-1:0]  imem_rdata,
  input  logic                stall,
  input  logic                redirect_valid,
  input  logic [31:0]         redirect_pc,
  output logic                instr_valid,
  output logic [INSTR_W-1:0]  instr,
  output logic [3:0]          opcode,
  output logic [31:0]         instr_pc
);
  fetch_state_e state, state_n;
  pc_op_e       pc_op;
  logic         tgt_we;
  logic         load;
  logic [31:0]  pc;

  fetch_pc #(.RESET_PC(RESET_PC)) u_pc (
    .clk         (clk),
    .rst         (rst),
    .op          (pc_op),
    .tgt_we      (tgt_we),
    .redirect_pc (redirect_pc),
    .pc          (pc)
  );

  // A held instruction blocks further fetch while decode stalls; the
  // request is also suppressed while reset is asserted.
  assign imem_req    = !rst && ((state != VALID) || !stall);
  assign imem_addr   = pc;
  assign instr_valid = (state == VALID);

  always_comb begin
    state_n = state;
    pc_op   = PC_HOLD;
    tgt_we  = 1'b0;
    load    = 1'b0;
    case (state)
      FETCH, VALID: begin
        if (redirect_valid) begin
          // An un-acked request must finish at its original address.
          if (imem_req && !imem_ack) begin
            tgt_we  = 1'b1;
            state_n = DRAIN;
          end else begin
            pc_op   = PC_REDIR;
            state_n = FETCH;
          end
        end else if (state == VALID && stall) begin
          state_n = VALID;
        end else if (imem_ack) begin
          load    = 1'b1;
          pc_op   = PC_INC;
          state_n = VALID;
        end else begin
          state_n = FETCH;
        end
      end
      DRAIN: begin
        if (redirect_valid) begin
          tgt_we = 1'b1;
          if (imem_ack) begin
            pc_op   = PC_REDIR;  // newest redirect wins
            state_n = FETCH;
          end
        end else if (imem_ack) begin
          pc_op   = PC_TARGET;
          state_n = FETCH;
        end
      end
      default: state_n = FETCH;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= FETCH;
      instr    <= '0;
      opcode   <= '0;
      instr_pc <= '0;
    end else begin
      state <= state_n;
      if (load) begin
        instr    <= imem_rdata;
        opcode   <= imem_rdata[OPCODE_MSB:OPCODE_LSB];
        instr_pc <= pc;
      end
    end
  end
endmodule

// File: tb/tb_instr_fetch.sv
module tb_instr_fetch;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        stall = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        instr_valid;
  logic [31:0] instr;
  logic [3:0]  opcode;
  logic [31:0] instr_pc;

  always #5 clk = ~clk;

  instr_fetch #(.RESET_PC(32'h0)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .stall(stall), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .instr_valid(instr_valid), .instr(instr), .opcode(opcode), .instr_pc(instr_pc)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] memf(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  // Reference model: output slot, next fetch address, pending redirect.
  logic        m_valid, m_drain;
  logic [31:0] m_addr, m_tgt, m_instr, m_ipc;
  logic        m_req;
  assign m_req = !rst && (!m_valid || !stall);

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_valid <= 1'b0; m_drain <= 1'b0; m_addr <= 32'h0;
      m_tgt <= 32'h0; m_instr <= 32'h0; m_ipc <= 32'h0;
    end else if (redirect_valid) begin
      m_valid <= 1'b0;
      if (m_req && !imem_ack) begin
        m_drain <= 1'b1;
        m_tgt   <= redirect_pc & 32'hFFFF_FFFC;
      end else begin
        m_drain <= 1'b0;
        m_addr  <= redirect_pc & 32'hFFFF_FFFC;
      end
    end else if (m_drain) begin
      if (imem_ack) begin
        m_drain <= 1'b0;
        m_addr  <= m_tgt;
      end
    end else if (m_valid && stall) begin
      m_valid <= 1'b1;
    end else if (imem_ack) begin
      m_valid <= 1'b1;
      m_instr <= imem_rdata;
      m_ipc   <= m_addr;
      m_addr  <= m_addr + 32'd4;
    end else begin
      m_valid <= 1'b0;
    end
  end

  // Compare process: registered outputs at negedge, request after inputs settle.
  always @(negedge clk) begin
    check("instr_valid", {31'b0, instr_valid}, {31'b0, m_valid});
    if (m_valid) begin
      check("instr", instr, m_instr);
      check("opcode", {28'b0, opcode}, {28'b0, m_instr[31:28]});
      check("instr_pc", instr_pc, m_ipc);
    end
    #3;
    check("imem_req", {31'b0, imem_req}, {31'b0, m_req});
    if (m_req) check("imem_addr", imem_addr, m_addr);
  end

  task automatic drive(input bit s, input bit rv, input logic [31:0] rp,
                       input bit a, input logic [31:0] d);
    @(negedge clk); #1;
    stall = s; redirect_valid = rv; redirect_pc = rp; imem_ack = a; imem_rdata = d;
    #1;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  int wcnt;

  initial begin
    // Reset held for three cycles.
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 0, 0, 0);
      check("rst_req", {31'b0, imem_req}, 32'd0);
      check("rst_valid", {31'b0, instr_valid}, 32'd0);
      step();
    end
    // Release and zero-wait stream.
    @(negedge clk); #1;
    rst = 1'b0; imem_ack = 1'b1; imem_rdata = 32'h1000_0000;
    #1;
    check("rel_req", {31'b0, imem_req}, 32'd1);
    check("rel_addr", imem_addr, 32'h0);
    step();
    check("s0_pc", instr_pc, 32'h0);
    check("s0_op", {28'b0, opcode}, 32'd1);
    drive(0, 0, 0, 1, 32'h2000_0000);
    check("s1_addr", imem_addr, 32'h4);
    step();
    check("s1_pc", instr_pc, 32'h4);
    check("s1_op", {28'b0, opcode}, 32'd2);
    // Stall three cycles while holding 0x4.
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 0, 0, 0);
      check("stall_req", {31'b0, imem_req}, 32'd0);
      check("stall_addr", imem_addr, 32'h8);
      step();
      check("stall_pc", instr_pc, 32'h4);
      check("stall_valid", {31'b0, instr_valid}, 32'd1);
    end
    drive(0, 0, 0, 1, 32'h3000_0000);
    step();
    check("s2_pc", instr_pc, 32'h8);
    check("s2_op", {28'b0, opcode}, 32'd3);
    // Redirect with an outstanding request, ack two cycles late.
    drive(0, 1, 32'h40, 0, 0);
    check("rd_addr", imem_addr, 32'hC);
    step();
    check("rd_valid", {31'b0, instr_valid}, 32'd0);
    drive(0, 0, 0, 0, 0);
    check("drain_addr", imem_addr, 32'hC);
    check("drain_req", {31'b0, imem_req}, 32'd1);
    step();
    drive(0, 0, 0, 1, 32'hF000_0000);
    check("drain_addr2", imem_addr, 32'hC);
    step();
    check("drain_discard", {31'b0, instr_valid}, 32'd0);
    drive(0, 0, 0, 1, 32'h5000_0000);
    check("tgt_addr", imem_addr, 32'h40);
    step();
    check("tgt_pc", instr_pc, 32'h40);
    check("tgt_op", {28'b0, opcode}, 32'd5);
    // Redirect during stall, unaligned target.
    drive(1, 1, 32'h43, 0, 0);
    check("rs_req", {31'b0, imem_req}, 32'd0);
    step();
    check("rs_valid", {31'b0, instr_valid}, 32'd0);
    drive(0, 0, 0, 1, 32'h6000_0000);
    check("rs_addr", imem_addr, 32'h40);
    step();
    check("rs_op", {28'b0, opcode}, 32'd6);
    // Redirect coinciding with an ack, to the top word; then wrap.
    drive(0, 1, 32'hFFFF_FFFC, 1, 32'hEEEE_EEEE);
    step();
    check("wr_valid", {31'b0, instr_valid}, 32'd0);
    drive(0, 0, 0, 1, 32'h7000_0000);
    check("wr_addr", imem_addr, 32'hFFFF_FFFC);
    step();
    check("wr_pc", instr_pc, 32'hFFFF_FFFC);
    drive(1, 0, 0, 0, 0);
    check("wrap_addr", imem_addr, 32'h0);
    step();
    // Enter DRAIN, then reset asynchronously.
    drive(0, 1, 32'h80, 0, 0);
    step();
    @(negedge clk); #1;
    redirect_valid = 1'b0; rst = 1'b1;
    #1;
    check("ar_req", {31'b0, imem_req}, 32'd0);
    check("ar_instr", instr, 32'h0);
    check("ar_pc", instr_pc, 32'h0);
    check("ar_op", {28'b0, opcode}, 32'd0);
    step();
    step();
    // Randomized phase against the model, memory with 0-2 wait cycles.
    @(negedge clk); #1;
    rst = 1'b0; imem_ack = 1'b0;
    wcnt = 0;
    for (int i = 0; i < 900; i++) begin
      @(negedge clk); #1;
      if (i == 450) rst = 1'b1;
      if (i == 452) rst = 1'b0;
      stall = ($urandom % 4 == 0);
      redirect_valid = ($urandom % 10 == 0);
      redirect_pc = ($urandom % 6 == 0) ? (32'hFFFF_FFF8 | ($urandom % 8)) : ($urandom % 4096);
      #1;
      if (rst) begin
        imem_ack = 1'b0; wcnt = 0;
      end else if (imem_req) begin
        if (wcnt == 0) begin
          imem_ack = 1'b1; imem_rdata = memf(imem_addr); wcnt = $urandom_range(0, 2);
        end else begin
          imem_ack = 1'b0; wcnt--;
        end
      end else begin
        imem_ack = 1'b0;
      end
    end
    @(negedge clk); #1;
    stall = 1'b0; redirect_valid = 1'b0; imem_ack = 1'b0;
    @(negedge clk); #4;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
